// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master bridge among NREQ requesters,
// with a watchdog that aborts accesses whose slave never completes.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no transfer owned; pick next requester round-robin
// ISSUE  | m_trans high, waiting for the bridge to reach its ENABLE phase
// WAIT   | ENABLE phase seen, waiting for PREADY / PSLVERR / watchdog
// DONE   | m_trans low, req_done pulse to owner; bridge returns to idle
module apb_rr_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [32*NREQ-1:0] req_addr,
    input  logic [32*NREQ-1:0] req_wdata,
    input  logic [4*NREQ-1:0]  req_strb,
    output logic [NREQ-1:0]    req_grant,
    output logic [NREQ-1:0]    req_done,
    output logic               req_err,
    output logic [31:0]        req_rdata,
    output logic               m_trans,
    output logic               m_rw,
    output logic [31:0]        m_waddr,
    output logic [31:0]        m_raddr,
    output logic [31:0]        m_wdata,
    output logic [3:0]         m_strb,
    input  logic               PENABLE,
    input  logic               PREADY,
    input  logic               PSLVERR,
    input  logic [31:0]        PRDATA
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     last_q, last_d;
    logic [7:0]        timer_q, timer_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              rw_q, rw_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        strb_q, strb_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       addr_arr  [NREQ];
    logic [31:0]       wdata_arr [NREQ];
    logic [3:0]        strb_arr  [NREQ];

    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     cand;
    logic [7:0]        timer_inc;
    logic              timeout;
    logic              complete;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[32*g +: 32];
        assign wdata_arr[g] = req_wdata[32*g +: 32];
        assign strb_arr[g]  = req_strb[4*g +: 4];
    end

    // Search starts one past the last owner and wraps modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign timer_inc = timer_q + 8'd1;
    assign timeout   = (timer_inc == 8'(TIMEOUT_CYC));
    assign complete  = PENABLE & PREADY;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= S_IDLE;
            last_q  <= IW'(NREQ - 1);
            timer_q <= '0;
            grant_q <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            grant_q <= grant_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // A zero-wait access completes while still in ISSUE, so DONE follows directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pick_found) state_d = S_ISSUE;
            S_ISSUE: begin
                if (complete || PSLVERR || timeout) state_d = S_DONE;
                else if (PENABLE)                   state_d = S_WAIT;
            end
            S_WAIT:  if (complete || PSLVERR || timeout) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        last_d  = last_q;
        timer_d = timer_q;
        grant_d = '0;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    last_d  = pick_idx;
                    timer_d = '0;
                    rw_d    = ~req_write[pick_idx];
                    addr_d  = addr_arr[pick_idx];
                    wdata_d = wdata_arr[pick_idx];
                    strb_d  = req_write[pick_idx] ? strb_arr[pick_idx] : 4'h0;
                    err_d   = 1'b0;
                end
            end
            S_ISSUE, S_WAIT: begin
                timer_d = timer_inc;
                if (complete) begin
                    err_d = PSLVERR;
                    if (rw_q) rdata_d = PRDATA;
                end else if (PSLVERR || timeout) begin
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        req_grant = grant_q;
        req_done  = '0;
        req_err   = 1'b0;
        m_trans   = 1'b0;
        if (state_q == S_DONE) begin
            req_done = {{(NREQ-1){1'b0}}, 1'b1} << last_q;
            req_err  = err_q;
        end
        if (state_q == S_ISSUE || state_q == S_WAIT) m_trans = 1'b1;
        req_rdata = rdata_q;
        m_rw      = rw_q;
        m_waddr   = addr_q;
        m_raddr   = addr_q;
        m_wdata   = wdata_q;
        m_strb    = strb_q;
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: behavioural bridge/slave model plus
// grant/done scoreboards checked when the arbiter pulses its outputs.
module tb_apb_rr_arbiter;

    localparam int NREQ = 4;
    localparam int TO   = 16;

    logic                PCLK = 1'b0;
    logic                PRESETn = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_write = '0;
    logic [32*NREQ-1:0]  req_addr = '0;
    logic [32*NREQ-1:0]  req_wdata = '0;
    logic [4*NREQ-1:0]   req_strb = '0;
    logic [NREQ-1:0]     req_grant, req_done;
    logic                req_err;
    logic [31:0]         req_rdata;
    logic                m_trans, m_rw;
    logic [31:0]         m_waddr, m_raddr, m_wdata;
    logic [3:0]          m_strb;
    logic                PENABLE, PREADY, PSLVERR;
    logic [31:0]         PRDATA;

    apb_rr_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb),
        .req_grant(req_grant), .req_done(req_done), .req_err(req_err),
        .req_rdata(req_rdata), .m_trans(m_trans), .m_rw(m_rw),
        .m_waddr(m_waddr), .m_raddr(m_raddr), .m_wdata(m_wdata), .m_strb(m_strb),
        .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    // Slave behaviour knobs, changed only while the bridge is idle.
    int          ws_cfg = 0;
    bit          never_cfg = 1'b0;
    bit          serr_cfg = 1'b0;
    logic [31:0] prd_cfg = 32'h0;

    typedef enum {B_IDLE, B_SETUP, B_EN} bst_t;
    bst_t b_st = B_IDLE;
    int   b_wait = 0;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            b_st <= B_IDLE;
        end else begin
            case (b_st)
                B_IDLE:  if (m_trans) b_st <= B_SETUP;
                B_SETUP: begin b_st <= B_EN; b_wait <= ws_cfg; end
                B_EN: begin
                    if (!m_trans || PREADY) b_st <= B_IDLE;
                    else if (b_wait > 0)    b_wait <= b_wait - 1;
                end
                default: b_st <= B_IDLE;
            endcase
        end
    end

    assign PENABLE = (b_st == B_EN);
    assign PREADY  = PENABLE && !never_cfg && (b_wait == 0);
    assign PSLVERR = PREADY && serr_cfg;
    assign PRDATA  = PENABLE ? prd_cfg : 32'h0;

    typedef struct {
        logic [NREQ-1:0] grant;
        logic            rw;
        logic [3:0]      strb;
        logic [31:0]     addr;
        logic [31:0]     wdata;
    } gexp_t;

    typedef struct {
        logic [NREQ-1:0] done;
        logic            err;
        logic [31:0]     rdata;
        int              lat;
    } dexp_t;

    gexp_t gq[$];
    dexp_t dq[$];
    gexp_t gm;
    dexp_t dm;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          g_cyc = 0;
    int          n_grant = 0;
    int          outstanding = 0;
    logic [31:0] exp_rd = 32'h0;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] all_outs();
        return {req_grant, req_done, req_err, req_rdata, m_trans, m_rw,
                m_waddr, m_raddr, m_wdata, m_strb};
    endfunction

    always @(posedge PCLK) cyc++;

    always @(negedge PCLK) begin
        if (PRESETn && (|req_grant || |req_done))
            chk("onehot_exclusive",
                $onehot0(req_grant) && $onehot0(req_done) && !(|req_grant && |req_done), 1);
        if (PRESETn && |req_grant) begin
            chk("grant_expected", gq.size() != 0, 1);
            chk("one_outstanding", outstanding, 0);
            if (gq.size() != 0) begin
                gm = gq.pop_front();
                chk("grant_vec", req_grant, gm.grant);
                chk("m_rw_strb", {m_rw, m_strb}, {gm.rw, gm.strb});
                chk("m_addr", {m_waddr, m_raddr}, {gm.addr, gm.addr});
                chk("m_wdata", m_wdata, gm.wdata);
                chk("m_trans_issue", m_trans, 1);
            end
            g_cyc = cyc;
            outstanding++;
            n_grant++;
        end
        if (PRESETn && |req_done) begin
            chk("done_expected", dq.size() != 0, 1);
            if (dq.size() != 0) begin
                dm = dq.pop_front();
                chk("done_vec", req_done, dm.done);
                chk("done_err", req_err, dm.err);
                chk("done_rdata", req_rdata, dm.rdata);
                chk("done_latency", cyc - g_cyc, dm.lat);
                chk("m_trans_done", m_trans, 0);
            end
            outstanding--;
        end
    end

    task automatic drive_req(input int i, input bit wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] s);
        req_write[i]          = wr;
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = wd;
        req_strb[4*i +: 4]    = s;
        req_valid[i]          = 1'b1;
    endtask

    // Expected outcome from the slave knobs: zero-wait done 3 cycles after grant.
    task automatic expect_xfer(input int i, input bit wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] s);
        gexp_t g;
        dexp_t d;
        logic [NREQ-1:0] one = 1;
        g.grant = one << i;
        g.rw    = !wr;
        g.strb  = wr ? s : 4'h0;
        g.addr  = a;
        g.wdata = wd;
        gq.push_back(g);
        if (!never_cfg && !wr) exp_rd = prd_cfg;
        d.done  = one << i;
        d.err   = never_cfg | serr_cfg;
        d.rdata = exp_rd;
        d.lat   = never_cfg ? TO : 3 + ws_cfg;
        dq.push_back(d);
    endtask

    task automatic wait_grants(input int n);
        int target = n_grant + n;
        for (int c = 0; c < 400 && n_grant < target; c++) begin
            @(posedge PCLK);
            #2;
        end
        chk("grant_wait", n_grant >= target, 1);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 400 && dq.size() != 0; c++) begin
            @(posedge PCLK);
            #2;
        end
        chk("drain_wait", dq.size(), 0);
    endtask

    task automatic apply_reset();
        PRESETn = 1'b0;
        #1;
        chk("reset_outputs", all_outs(), 0);
        gq.delete();
        dq.delete();
        outstanding = 0;
        exp_rd = 32'h0;
        req_valid = '0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge PCLK);
        #1;
        chk("reset_outputs_initial", all_outs(), 0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // single zero-wait write from requester 0
        drive_req(0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF);
        expect_xfer(0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF);
        wait_grants(1);
        req_valid = '0;
        wait_drain();

        // read with two wait states, strobes forced to zero
        ws_cfg = 2; prd_cfg = 32'h1234_5678;
        drive_req(2, 1'b0, 32'h8000_0004, 32'h0, 4'hF);
        expect_xfer(2, 1'b0, 32'h8000_0004, 32'h0, 4'hF);
        wait_grants(1);
        req_valid = '0;
        wait_drain();

        // all four continuously valid from reset: 0,1,2,3,0,1
        apply_reset();
        ws_cfg = 0; prd_cfg = 32'hCAFE_0001;
        for (int i = 0; i < NREQ; i++)
            drive_req(i, (i % 2) == 0, 32'h100 + 32'(i * 4), 32'h5000 + 32'(i), 4'(i + 1));
        for (int n = 0; n < 6; n++)
            expect_xfer(n % NREQ, ((n % NREQ) % 2) == 0, 32'h100 + 32'((n % NREQ) * 4),
                        32'h5000 + 32'(n % NREQ), 4'((n % NREQ) + 1));
        wait_grants(6);
        req_valid = '0;
        wait_drain();

        // slave never ready: watchdog aborts, rdata unchanged
        never_cfg = 1'b1; prd_cfg = 32'hDEAD_0000;
        drive_req(3, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
        expect_xfer(3, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
        wait_grants(1);
        req_valid = '0;
        wait_drain();

        // completion on the same edge the watchdog expires: normal result
        never_cfg = 1'b0; ws_cfg = TO - 3; prd_cfg = 32'h0BAD_F00D;
        drive_req(0, 1'b0, 32'h0000_0400, 32'h0, 4'h3);
        expect_xfer(0, 1'b0, 32'h0000_0400, 32'h0, 4'h3);
        wait_grants(1);
        req_valid = '0;
        wait_drain();

        // PSLVERR with PREADY on a read from requester 1
        ws_cfg = 0; serr_cfg = 1'b1; prd_cfg = 32'h5555_AAAA;
        drive_req(1, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
        expect_xfer(1, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
        wait_grants(1);
        req_valid = '0;
        wait_drain();

        // requesters 0 and 2 both valid: pointer continues at 2, then wraps to 0
        serr_cfg = 1'b0;
        drive_req(0, 1'b1, 32'h0000_0600, 32'h6666_0000, 4'hC);
        drive_req(2, 1'b1, 32'h0000_0620, 32'h6666_0002, 4'h5);
        expect_xfer(2, 1'b1, 32'h0000_0620, 32'h6666_0002, 4'h5);
        expect_xfer(0, 1'b1, 32'h0000_0600, 32'h6666_0000, 4'hC);
        wait_grants(1);
        req_valid[2] = 1'b0;
        wait_grants(1);
        req_valid = '0;
        wait_drain();

        // reset while the transfer is in WAIT: no done, pointer back to requester 0 first
        never_cfg = 1'b1;
        drive_req(1, 1'b0, 32'h0000_0700, 32'h0, 4'h0);
        expect_xfer(1, 1'b0, 32'h0000_0700, 32'h0, 4'h0);
        wait_grants(1);
        req_valid = '0;
        repeat (3) @(posedge PCLK);
        #3;
        chk("m_trans_in_wait", m_trans, 1);
        apply_reset();
        never_cfg = 1'b0;
        drive_req(0, 1'b1, 32'h0000_0800, 32'h8888_0000, 4'hF);
        drive_req(3, 1'b1, 32'h0000_0830, 32'h8888_0003, 4'hF);
        expect_xfer(0, 1'b1, 32'h0000_0800, 32'h8888_0000, 4'hF);
        expect_xfer(3, 1'b1, 32'h0000_0830, 32'h8888_0003, 4'hF);
        wait_grants(1);
        req_valid[0] = 1'b0;
        wait_grants(1);
        req_valid = '0;
        wait_drain();

        repeat (4) @(posedge PCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
